// File: rtl/led_blink_multi.sv
//------------------------------------------------------------------------------
// led_blink_multi
//
// Multi-channel LED driver. It sits between a control/CSR block and the LED
// pins. Each channel runs in one of four modes: OFF, ON, BLINK (toggle timed
// by a per-channel divider) or PWM (brightness set by a per-channel duty
// compared against one shared free-running counter). Channels are
// configured through a one-cycle write port. A global sync pulse
// phase-aligns every channel's divider and the shared PWM counter.
//
// Ports
//   i_clk       system clock, all logic on its rising edge
//   i_rst       synchronous active-high reset, overrides every other input
//   i_cfg_we    config write strobe, one write per asserted cycle
//   i_cfg_ch    target channel index; indices >= NUM_CH are ignored
//   i_cfg_mode  0=OFF, 1=ON, 2=BLINK, 3=PWM
//   i_cfg_div   blink divider value (toggle period = div+1 cycles)
//   i_cfg_duty  PWM duty value (high while pwm counter < duty)
//   i_sync      clears every divider, every blink phase and the PWM counter
//   o_led       registered LED drive, bit i = channel i
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module led_blink_multi #(
    parameter int  NUM_CH  = 4,
    parameter int  CNT_W   = 32,
    parameter int  DIV_RST = 10000000,
    parameter int  PWM_W   = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [CNT_W-1:0]  i_cfg_div,
    input  logic [PWM_W-1:0]  i_cfg_duty,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_led
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Channel count widened by one bit so it can be compared against any
    // cfg_ch value, including the case where NUM_CH is a power of two.
    localparam logic [CH_W:0]    NUM_CH_W   = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] DIV_RST_W  = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [PWM_W-1:0] PWM_ONE    = PWM_W'(1'b1);

    // Per-channel configuration and divider state
    mode_e             r_mode  [NUM_CH];
    logic [CNT_W-1:0]  r_div   [NUM_CH];
    logic [PWM_W-1:0]  r_duty  [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];
    logic [NUM_CH-1:0] r_blink;

    // Shared PWM counter and output register
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [NUM_CH-1:0] r_led;

    // Combinational next-state values
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_wr_sel;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_blink_nxt;
    logic [NUM_CH-1:0] w_led_nxt;
    logic [PWM_W-1:0]  w_pwm_nxt;

    // Write decode: one-hot channel select, empty for out-of-range indices
    always_comb begin
        w_ch_ok  = ({1'b0, i_cfg_ch} < NUM_CH_W);
        w_wr_sel = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_cfg_we && w_ch_ok && (i_cfg_ch == CH_W'(c))) begin
                w_wr_sel[c] = 1'b1;
            end else begin
                w_wr_sel[c] = 1'b0;
            end
        end
    end

    // Divider next state; a write or sync takes priority over a wrap so a
    // colliding write always restarts the channel from a clean phase
    always_comb begin
        w_blink_nxt = r_blink;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cnt_nxt[c] = r_cnt[c];
            if (w_wr_sel[c] || i_sync) begin
                w_cnt_nxt[c]   = {CNT_W{1'b0}};
                w_blink_nxt[c] = 1'b0;
            end else if (r_cnt[c] < r_div[c]) begin
                w_cnt_nxt[c]   = r_cnt[c] + CNT_ONE;
                w_blink_nxt[c] = r_blink[c];
            end else begin
                w_cnt_nxt[c]   = {CNT_W{1'b0}};
                w_blink_nxt[c] = ~r_blink[c];
            end
        end
    end

    // Shared PWM counter next state: free-running, cleared only by sync
    always_comb begin
        w_pwm_nxt = r_pwm_cnt + PWM_ONE;
        if (i_sync) begin
            w_pwm_nxt = {PWM_W{1'b0}};
        end else begin
            w_pwm_nxt = r_pwm_cnt + PWM_ONE;
        end
    end

    // LED next value from pre-edge state, so a blink toggle reaches the pin
    // one cycle after it happens in the divider
    always_comb begin
        w_led_nxt = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            case (r_mode[c])
                MODE_OFF:   w_led_nxt[c] = 1'b0;
                MODE_ON:    w_led_nxt[c] = 1'b1;
                MODE_BLINK: w_led_nxt[c] = r_blink[c];
                MODE_PWM:   w_led_nxt[c] = (r_pwm_cnt < r_duty[c]);
                default:    w_led_nxt[c] = 1'b0;
            endcase
        end
    end

    // Per-channel state registers: reset, config load and divider update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_mode[c] <= MODE_BLINK;
                r_div[c]  <= DIV_RST_W;
                r_duty[c] <= {PWM_W{1'b0}};
                r_cnt[c]  <= {CNT_W{1'b0}};
            end
            r_blink <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= w_cnt_nxt[c];
                if (w_wr_sel[c]) begin
                    r_mode[c] <= mode_e'(i_cfg_mode);
                    r_div[c]  <= i_cfg_div;
                    r_duty[c] <= i_cfg_duty;
                end else begin
                    r_mode[c] <= r_mode[c];
                    r_div[c]  <= r_div[c];
                    r_duty[c] <= r_duty[c];
                end
            end
            r_blink <= w_blink_nxt;
        end
    end

    // Shared PWM counter and LED output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_cnt <= {PWM_W{1'b0}};
            r_led     <= {NUM_CH{1'b0}};
        end else begin
            r_pwm_cnt <= w_pwm_nxt;
            r_led     <= w_led_nxt;
        end
    end

    assign o_led = r_led;

endmodule

// File: tb/tb_led_blink_multi.sv
//------------------------------------------------------------------------------
// tb_led_blink_multi
//
// Directed plus randomized bench for led_blink_multi. The reference model
// describes each channel by its configuration and the number of edges since
// it was last aligned (reset, sync or write); blink level and PWM level are
// then computed with plain division and modulo arithmetic.
// Five channels are used so that an index past the last channel is
// representable on the 3-bit cfg_ch port.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_led_blink_multi;

    localparam int NCH  = 5;
    localparam int CW   = 32;
    localparam int DIVR = 9;
    localparam int PW   = 8;
    localparam longint PWM_MOD = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [2:0]      cfg_ch;
    logic [1:0]      cfg_mode;
    logic [CW-1:0]   cfg_div;
    logic [PW-1:0]   cfg_duty;
    logic            sync;
    logic [NCH-1:0]  led;

    led_blink_multi #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DIV_RST (DIVR),
        .PWM_W   (PW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_we   (cfg_we),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_mode (cfg_mode),
        .i_cfg_div  (cfg_div),
        .i_cfg_duty (cfg_duty),
        .i_sync     (sync),
        .o_led      (led)
    );

    always #5 clk = ~clk;

    // Reference model
    int             m_mode [NCH];
    longint         m_div  [NCH];
    int             m_duty [NCH];
    longint         m_t    [NCH];   // edges since channel alignment
    longint         m_pwm;          // edges since PWM alignment
    logic [NCH-1:0] m_led;

    int n_cmp;
    int n_err;
    int edge_n;
    int tog[$];

    function automatic logic exp_led(input int c);
        case (m_mode[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_t[c] / (m_div[c] + 1)) % 2) == 1;
            default: return (m_pwm % PWM_MOD) < longint'(m_duty[c]);
        endcase
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare led
    task automatic step(input logic s_rst, input logic s_we, input int s_ch,
                        input int s_mode, input longint s_div, input int s_duty,
                        input logic s_sync);
        rst      = s_rst;
        cfg_we   = s_we;
        cfg_ch   = 3'(s_ch);
        cfg_mode = 2'(s_mode);
        cfg_div  = 32'(s_div);
        cfg_duty = 8'(s_duty);
        sync     = s_sync;
        @(posedge clk);
        if (s_rst) begin
            m_led = '0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 2; m_div[c] = DIVR; m_duty[c] = 0; m_t[c] = 0;
            end
            m_pwm = 0;
        end else begin
            for (int c = 0; c < NCH; c++) m_led[c] = exp_led(c);
            for (int c = 0; c < NCH; c++) m_t[c]++;
            m_pwm++;
            if (s_sync) begin
                for (int c = 0; c < NCH; c++) m_t[c] = 0;
                m_pwm = 0;
            end
            if (s_we && s_ch < NCH) begin
                m_mode[s_ch] = s_mode; m_div[s_ch] = s_div;
                m_duty[s_ch] = s_duty; m_t[s_ch] = 0;
            end
        end
        edge_n++;
        #1;
        n_cmp++;
        assert (led === m_led) else begin
            n_err++;
            $error("FAIL led edge=%0d observed=%b expected=%b", edge_n, led, m_led);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int ch, input int mode, input longint div, input int duty);
        step(1'b0, 1'b1, ch, mode, div, duty, 1'b0);
    endtask

    // Record edges (relative to base) at which led[ch] changes
    task automatic watch(input int ch, input int n, input int base);
        logic prev;
        tog.delete();
        prev = led[ch];
        for (int k = 0; k < n; k++) begin
            idle();
            if (led[ch] !== prev) begin
                tog.push_back(edge_n - base);
                prev = led[ch];
            end
        end
    endtask

    function automatic int tog_at(input int k);
        return (tog.size() > k) ? tog[k] : -1;
    endfunction

    // PWM on ch3, window aligned to the PWM counter by a sync with the write
    task automatic pwm_run(input int duty, input int e_high, input int e_runs, input int e_max);
        int   high, runs, run, maxrun;
        logic prev;
        step(1'b0, 1'b1, 3, 3, 0, duty, 1'b1);
        high = 0; runs = 0; run = 0; maxrun = 0; prev = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            idle();
            if (led[3] === 1'b1) begin
                high++; run++;
                if (prev !== 1'b1) runs++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            prev = led[3];
        end
        chk($sformatf("pwm%0d_high", duty), high, e_high);
        chk($sformatf("pwm%0d_runs", duty), runs, e_runs);
        chk($sformatf("pwm%0d_maxrun", duty), maxrun, e_max);
    endtask

    initial begin
        int base, s, r0, r1, gap;
        n_cmp = 0; n_err = 0; edge_n = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_mode = 2'd0;
        cfg_div = '0; cfg_duty = '0; sync = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2; m_div[c] = DIVR; m_duty[c] = 0; m_t[c] = 0;
        end
        m_pwm = 0; m_led = '0;

        // Reset held two cycles, then free-run with every channel in BLINK
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        chk("rst_led", led, 0);
        base = edge_n;
        watch(0, 100, base);
        chk("rst_ntog", tog.size(), 9);
        chk("rst_rise1", tog_at(0), 11);
        chk("rst_tog2", tog_at(1), 21);
        chk("rst_tog3", tog_at(2), 31);

        // BLINK ch1 div=3: toggles every 4 edges, first rise 5 edges after write
        wr(1, 2, 3, 0);
        base = edge_n;
        idle();
        chk("blink_w1", led[1], 0);
        watch(1, 14, base);
        chk("blink_rise1", tog_at(0), 5);
        chk("blink_tog2", tog_at(1), 9);
        chk("blink_tog3", tog_at(2), 13);

        // ON then OFF on ch2, ten cycles apart, no glitch in between
        wr(2, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            idle();
            chk("on_hold", led[2], 1);
        end
        wr(2, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("off_hold", led[2], 0);
        end

        // PWM duty sweep over 1024 cycles
        pwm_run(64, 256, 4, 64);
        pwm_run(0, 0, 0, 0);
        pwm_run(255, 1020, 4, 255);

        // Out-of-range channel index: no state or led change anywhere
        wr(5, 1, 0, 200);
        wr(7, 0, 1, 10);
        for (int k = 0; k < 20; k++) idle();

        // Write on the wrap cycle of ch1: write wins, next toggle after div+1
        wr(1, 2, 3, 0);
        for (int k = 0; k < 8 && (m_t[1] % 4) != 3; k++) idle();
        chk("coll_at_wrap", m_t[1] % 4, 3);
        wr(1, 2, 3, 0);
        base = edge_n;
        idle();
        chk("coll_w1", led[1], 0);
        watch(1, 10, base);
        chk("coll_rise1", tog_at(0), 5);
        chk("coll_tog2", tog_at(1), 9);

        // Sync realigns ch0 (div 4) and ch1 (div 6) from random phases
        wr(0, 2, 4, 0);
        gap = $urandom_range(1, 9);
        for (int k = 0; k < gap; k++) idle();
        wr(1, 2, 6, 0);
        gap = $urandom_range(3, 20);
        for (int k = 0; k < gap; k++) idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        s = edge_n;
        r0 = -1; r1 = -1;
        for (int k = 0; k < 15; k++) begin
            idle();
            if (r0 < 0 && led[0] === 1'b1) r0 = edge_n - s;
            if (r1 < 0 && led[1] === 1'b1) r1 = edge_n - s;
        end
        chk("sync_ch0_rise", r0, 6);
        chk("sync_ch1_rise", r1, 8);

        // Reset with a simultaneous write: write dropped, ch2 back to BLINK
        step(1'b1, 1'b1, 2, 1, 5, 0, 1'b0);
        chk("rst_mid_led", led, 0);
        base = edge_n;
        watch(2, 25, base);
        chk("rst_mid_rise1", tog_at(0), 11);
        chk("rst_mid_tog2", tog_at(1), 21);

        // Randomized writes, syncs and occasional resets against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                     $urandom_range(0, 3), $urandom_range(0, 12),
                     $urandom_range(0, 255), $urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 7) == 0) begin
                step(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 12), $urandom_range(0, 255),
                     $urandom_range(0, 39) == 0);
            end else begin
                step(1'b0, 1'b0, 0, 0, 0, 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
